// File: rtl/regfile_pkg.sv
// Shared types and default sizes for the multi-port integer register file.
// Decode and issue logic import the same definitions.
package regfile_pkg;

  localparam int unsigned XLEN_DEFAULT  = 32;
  localparam int unsigned NREGS_DEFAULT = 32;

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } state_e;

endpackage

// File: rtl/regfile_read_port.sv
// One combinational read port: handles the zero index, the not-ready state
// and same-cycle write forwarding, where port 1 takes priority over port 0.
module regfile_read_port #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned AW     = 5,
  parameter int unsigned BYPASS = 1
) (
  input  logic            i_ready,
  input  logic [AW-1:0]   i_rs,
  input  logic [XLEN-1:0] i_arr_data,
  input  logic            i_we0,
  input  logic [AW-1:0]   i_rd0,
  input  logic [XLEN-1:0] i_wd0,
  input  logic            i_we1,
  input  logic [AW-1:0]   i_rd1,
  input  logic [XLEN-1:0] i_wd1,
  output logic [XLEN-1:0] o_rdata_c
);

  logic w_fwd1;
  logic w_fwd0;

  assign w_fwd1 = (BYPASS != 0) && i_we1 && (i_rd1 == i_rs);
  assign w_fwd0 = (BYPASS != 0) && i_we0 && (i_rd0 == i_rs);

  always_comb begin
    o_rdata_c = i_arr_data;
    if (!i_ready || (i_rs == '0)) begin
      o_rdata_c = '0;
    end else if (w_fwd1) begin
      o_rdata_c = i_wd1;
    end else if (w_fwd0) begin
      o_rdata_c = i_wd0;
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// Integer register file: 2 combinational read ports, 2 write ports, x0 tied to zero.
// The array has no reset; a clear sequencer sweeps it to zero after reset or on request.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter  int unsigned XLEN   = XLEN_DEFAULT,
  parameter  int unsigned NREGS  = NREGS_DEFAULT,
  parameter  int unsigned BYPASS = 1,
  localparam int unsigned AW     = $clog2(NREGS)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clear,
  output logic            ready,
  input  logic            we0,
  input  logic [AW-1:0]   rd0,
  input  logic [XLEN-1:0] wd0,
  input  logic            we1,
  input  logic [AW-1:0]   rd1,
  input  logic [XLEN-1:0] wd1,
  input  logic [AW-1:0]   rs1,
  input  logic [AW-1:0]   rs2,
  output logic [XLEN-1:0] rdata1,
  output logic [XLEN-1:0] rdata2
);

  localparam logic [AW-1:0] LAST_IDX  = AW'(NREGS - 1);
  localparam logic [AW-1:0] FIRST_IDX = AW'(1);

  state_e          r_state;
  state_e          w_state_nxt;
  logic [AW-1:0]   r_clr_idx;
  logic [AW-1:0]   w_clr_idx_nxt;
  logic            r_ready;
  logic            w_ready_nxt;
  logic [XLEN-1:0] r_regs [NREGS];
  logic            w_wr0;
  logic            w_wr1;

  // Sequencer state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= CLEAR;
      r_clr_idx <= FIRST_IDX;
      r_ready   <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_clr_idx <= w_clr_idx_nxt;
      r_ready   <= w_ready_nxt;
    end
  end

  // Sequencer next state: sweep 1..NREGS-1, then idle until clear
  always_comb begin
    w_state_nxt   = r_state;
    w_clr_idx_nxt = r_clr_idx;
    w_ready_nxt   = r_ready;
    case (r_state)
      CLEAR: begin
        if (r_clr_idx == LAST_IDX) begin
          w_state_nxt = READY;
          w_ready_nxt = 1'b1;
        end else begin
          w_clr_idx_nxt = r_clr_idx + AW'(1);
        end
      end
      READY: begin
        if (clear) begin
          w_state_nxt   = CLEAR;
          w_clr_idx_nxt = FIRST_IDX;
          w_ready_nxt   = 1'b0;
        end
      end
      default: begin
        w_state_nxt   = CLEAR;
        w_clr_idx_nxt = FIRST_IDX;
        w_ready_nxt   = 1'b0;
      end
    endcase
  end

  assign w_wr0 = (r_state == READY) && we0 && (rd0 != '0);
  assign w_wr1 = (r_state == READY) && we1 && (rd1 != '0);

  // Storage array; port 1 is written last so it wins a same-index conflict
  always_ff @(posedge clk) begin
    if (r_state == CLEAR) begin
      r_regs[r_clr_idx] <= '0;
    end else begin
      if (w_wr0) begin
        r_regs[rd0] <= wd0;
      end
      if (w_wr1) begin
        r_regs[rd1] <= wd1;
      end
    end
  end

  assign ready = r_ready;

  regfile_read_port #(
    .XLEN  (XLEN),
    .AW    (AW),
    .BYPASS(BYPASS)
  ) u_read_a (
    .i_ready   (r_ready),
    .i_rs      (rs1),
    .i_arr_data(r_regs[rs1]),
    .i_we0     (we0),
    .i_rd0     (rd0),
    .i_wd0     (wd0),
    .i_we1     (we1),
    .i_rd1     (rd1),
    .i_wd1     (wd1),
    .o_rdata_c (rdata1)
  );

  regfile_read_port #(
    .XLEN  (XLEN),
    .AW    (AW),
    .BYPASS(BYPASS)
  ) u_read_b (
    .i_ready   (r_ready),
    .i_rs      (rs2),
    .i_arr_data(r_regs[rs2]),
    .i_we0     (we0),
    .i_rd0     (rd0),
    .i_wd0     (wd0),
    .i_we1     (we1),
    .i_rd1     (rd1),
    .i_wd1     (wd1),
    .o_rdata_c (rdata2)
  );

endmodule

// File: tb/tb_regfile_mp.sv
// Scoreboard bench for regfile_mp: a forwarding build and a non-forwarding build
// share the same stimulus; expectations are queued at drive time and checked at sample time.
module tb_regfile_mp;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned NREGS = 32;
  localparam int unsigned AW    = 5;

  logic            clk;
  logic            rst;
  logic            clear;
  logic            we0, we1;
  logic [AW-1:0]   rd0, rd1, rs1, rs2;
  logic [XLEN-1:0] wd0, wd1;
  logic            ready, nb_ready;
  logic [XLEN-1:0] rdata1, rdata2, nb_rdata1, nb_rdata2;

  typedef struct {
    int          sel;
    string       name;
    logic [31:0] exp;
  } exp_t;

  exp_t sb_q[$];
  int   n_vec;
  int   n_err;

  regfile_mp #(.XLEN(XLEN), .NREGS(NREGS), .BYPASS(1)) u_dut (
    .clk(clk), .rst(rst), .clear(clear), .ready(ready),
    .we0(we0), .rd0(rd0), .wd0(wd0), .we1(we1), .rd1(rd1), .wd1(wd1),
    .rs1(rs1), .rs2(rs2), .rdata1(rdata1), .rdata2(rdata2)
  );

  regfile_mp #(.XLEN(XLEN), .NREGS(NREGS), .BYPASS(0)) u_dut_nb (
    .clk(clk), .rst(rst), .clear(clear), .ready(nb_ready),
    .we0(we0), .rd0(rd0), .wd0(wd0), .we1(we1), .rd1(rd1), .wd1(wd1),
    .rs1(rs1), .rs2(rs2), .rdata1(nb_rdata1), .rdata2(nb_rdata2)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] obs(input int sel);
    case (sel)
      0:       obs = {31'b0, ready};
      1:       obs = rdata1;
      2:       obs = rdata2;
      3:       obs = nb_rdata1;
      4:       obs = nb_rdata2;
      5:       obs = {31'b0, nb_ready};
      default: obs = '0;
    endcase
  endfunction

  task automatic push(input int sel, input string name, input logic [31:0] v);
    exp_t e;
    e.sel  = sel;
    e.name = name;
    e.exp  = v;
    sb_q.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle();
    we0 = 1'b0; we1 = 1'b0; clear = 1'b0;
    rd0 = '0; rd1 = '0; wd0 = '0; wd1 = '0;
  endtask

  // Writes x[i] = i*mult for i = 1..31, two registers per cycle
  task automatic fill(input int mult);
    for (int i = 1; i < 32; i += 2) begin
      we0 = 1'b1; rd0 = AW'(i); wd0 = 32'(i * mult);
      we1 = (i + 1 < 32); rd1 = AW'(i + 1); wd1 = 32'((i + 1) * mult);
      step();
    end
    idle();
  endtask

  task automatic test_reset();
    exp_t e;
    rst = 1'b1; rs1 = AW'(5); rs2 = '0;
    idle();
    repeat (3) step();
    push(0, "rst_ready", 32'd0);
    push(1, "rst_rdata1", 32'd0);
    #1;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front(); n_vec++;
      if (obs(e.sel) !== e.exp) begin
        n_err++; $display("FAIL %s: got %h want %h", e.name, obs(e.sel), e.exp);
      end
    end
    rst = 1'b0;
    for (int k = 0; k < 31; k++) begin
      push(0, "sweep_ready", 32'd0);
      push(1, "sweep_rdata1", 32'd0);
      #1;
      while (sb_q.size() > 0) begin
        e = sb_q.pop_front(); n_vec++;
        if (obs(e.sel) !== e.exp) begin
          n_err++; $display("FAIL %s edge %0d: got %h want %h", e.name, k, obs(e.sel), e.exp);
        end
      end
      step();
    end
    push(0, "ready_after_31", 32'd1);
    push(5, "nb_ready_after_31", 32'd1);
    push(1, "x5_zero", 32'd0);
    #1;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front(); n_vec++;
      if (obs(e.sel) !== e.exp) begin
        n_err++; $display("FAIL %s: got %h want %h", e.name, obs(e.sel), e.exp);
      end
    end
  endtask

  task automatic test_basic();
    exp_t e;
    we0 = 1'b1; rd0 = AW'(7); wd0 = 32'hDEADBEEF; rs1 = '0;
    step();
    we0 = 1'b0; rs1 = AW'(7);
    push(1, "rd_x7", 32'hDEADBEEF);
    push(3, "nb_rd_x7", 32'hDEADBEEF);
    we0 = 1'b1; rd0 = '0; wd0 = 32'h1234; rs2 = '0;
    push(2, "x0_fwd_zero", 32'd0);
    #1;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front(); n_vec++;
      if (obs(e.sel) !== e.exp) begin
        n_err++; $display("FAIL %s: got %h want %h", e.name, obs(e.sel), e.exp);
      end
    end
    step();
    idle();
    push(2, "x0_zero", 32'd0);
    push(4, "nb_x0_zero", 32'd0);
    #1;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front(); n_vec++;
      if (obs(e.sel) !== e.exp) begin
        n_err++; $display("FAIL %s: got %h want %h", e.name, obs(e.sel), e.exp);
      end
    end
  endtask

  task automatic test_dual_write();
    exp_t e;
    we0 = 1'b1; rd0 = AW'(9); wd0 = 32'h1111;
    we1 = 1'b1; rd1 = AW'(9); wd1 = 32'h2222; rs1 = AW'(9);
    push(1, "conflict_fwd", 32'h2222);
    push(3, "nb_conflict_old", 32'h0);
    #1;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front(); n_vec++;
      if (obs(e.sel) !== e.exp) begin
        n_err++; $display("FAIL %s: got %h want %h", e.name, obs(e.sel), e.exp);
      end
    end
    step();
    rd0 = AW'(3); wd0 = 32'h33; rd1 = AW'(4); wd1 = 32'h44;
    rs1 = AW'(3); rs2 = AW'(4);
    push(1, "distinct_fwd0", 32'h33);
    push(2, "distinct_fwd1", 32'h44);
    #1;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front(); n_vec++;
      if (obs(e.sel) !== e.exp) begin
        n_err++; $display("FAIL %s: got %h want %h", e.name, obs(e.sel), e.exp);
      end
    end
    step();
    idle();
    push(1, "x3_commit", 32'h33);
    push(2, "x4_commit", 32'h44);
    push(3, "nb_x3_commit", 32'h33);
    push(4, "nb_x4_commit", 32'h44);
    rs2 = AW'(9);
    #1;
    push(2, "x9_port1_wins", 32'h2222);
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front(); n_vec++;
      if (e.sel == 2 && e.name == "x4_commit") begin
        rs2 = AW'(4); #1;
      end else if (e.sel == 2) begin
        rs2 = AW'(9); #1;
      end
      if (obs(e.sel) !== e.exp) begin
        n_err++; $display("FAIL %s: got %h want %h", e.name, obs(e.sel), e.exp);
      end
    end
  endtask

  task automatic test_bypass();
    exp_t e;
    we0 = 1'b1; rd0 = AW'(6); wd0 = 32'hA;
    step();
    idle();
    we0 = 1'b1; rd0 = AW'(6); wd0 = 32'hC;
    we1 = 1'b1; rd1 = AW'(6); wd1 = 32'hB; rs1 = AW'(6); rs2 = AW'(6);
    push(1, "fwd_port1_prio", 32'hB);
    push(3, "nb_old_value", 32'hA);
    #1;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front(); n_vec++;
      if (obs(e.sel) !== e.exp) begin
        n_err++; $display("FAIL %s: got %h want %h", e.name, obs(e.sel), e.exp);
      end
    end
    step();
    idle();
    we0 = 1'b1; rd0 = AW'(6); wd0 = 32'hD;
    push(2, "fwd_port0", 32'hD);
    push(4, "nb_next_cycle", 32'hB);
    #1;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front(); n_vec++;
      if (obs(e.sel) !== e.exp) begin
        n_err++; $display("FAIL %s: got %h want %h", e.name, obs(e.sel), e.exp);
      end
    end
    step();
    idle();
    push(1, "x6_final", 32'hD);
    push(3, "nb_x6_final", 32'hD);
    #1;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front(); n_vec++;
      if (obs(e.sel) !== e.exp) begin
        n_err++; $display("FAIL %s: got %h want %h", e.name, obs(e.sel), e.exp);
      end
    end
  endtask

  // Runs one full sweep, driving a write to x2 that must be dropped, then checks all zero
  task automatic sweep_and_check(input string tag);
    exp_t e;
    for (int k = 0; k < 31; k++) begin
      we0 = 1'b1; rd0 = AW'(2); wd0 = 32'h5; rs1 = AW'(2);
      push(0, {tag, "_sweep_ready"}, 32'd0);
      push(1, {tag, "_sweep_rd"}, 32'd0);
      #1;
      while (sb_q.size() > 0) begin
        e = sb_q.pop_front(); n_vec++;
        if (obs(e.sel) !== e.exp) begin
          n_err++; $display("FAIL %s edge %0d: got %h want %h", e.name, k, obs(e.sel), e.exp);
        end
      end
      step();
    end
    idle();
    push(0, {tag, "_ready"}, 32'd1);
    for (int i = 1; i < 32; i++) push(1, {tag, "_zero"}, 32'd0);
    #1;
    for (int i = 0; sb_q.size() > 0; i++) begin
      e = sb_q.pop_front(); n_vec++;
      rs1 = AW'(i); #1;
      if (obs(e.sel) !== e.exp) begin
        n_err++; $display("FAIL %s x%0d: got %h want %h", e.name, i, obs(e.sel), e.exp);
      end
    end
  endtask

  task automatic test_clear();
    exp_t e;
    fill(1);
    for (int i = 1; i < 32; i++) push(1, "fill_x", 32'(i));
    for (int i = 1; sb_q.size() > 0; i++) begin
      e = sb_q.pop_front(); n_vec++;
      rs1 = AW'(i); #1;
      if (obs(e.sel) !== e.exp) begin
        n_err++; $display("FAIL %s%0d: got %h want %h", e.name, i, obs(e.sel), e.exp);
      end
    end
    clear = 1'b1;
    step();
    clear = 1'b0;
    sweep_and_check("soft");
  endtask

  task automatic test_rst_mid_clear();
    exp_t e;
    fill(3);
    clear = 1'b1;
    step();
    clear = 1'b0;
    repeat (9) step();
    rst = 1'b1; rs1 = AW'(4);
    push(0, "midrst_ready", 32'd0);
    push(1, "midrst_rd", 32'd0);
    #1;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front(); n_vec++;
      if (obs(e.sel) !== e.exp) begin
        n_err++; $display("FAIL %s: got %h want %h", e.name, obs(e.sel), e.exp);
      end
    end
    step();
    rst = 1'b0;
    sweep_and_check("midrst");
  endtask

  task automatic test_clear_held();
    exp_t e;
    clear = 1'b1;
    step();
    repeat (31) step();
    push(0, "held_pulse_hi", 32'd1);
    #1;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front(); n_vec++;
      if (obs(e.sel) !== e.exp) begin
        n_err++; $display("FAIL %s: got %h want %h", e.name, obs(e.sel), e.exp);
      end
    end
    step();
    push(0, "held_pulse_lo", 32'd0);
    #1;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front(); n_vec++;
      if (obs(e.sel) !== e.exp) begin
        n_err++; $display("FAIL %s: got %h want %h", e.name, obs(e.sel), e.exp);
      end
    end
    clear = 1'b0;
    repeat (31) step();
    push(0, "held_final_ready", 32'd1);
    #1;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front(); n_vec++;
      if (obs(e.sel) !== e.exp) begin
        n_err++; $display("FAIL %s: got %h want %h", e.name, obs(e.sel), e.exp);
      end
    end
  endtask

  initial begin
    clk = 1'b0;
    n_vec = 0;
    n_err = 0;
    rs1 = '0; rs2 = '0;
    test_reset();
    test_basic();
    test_dual_write();
    test_bypass();
    test_clear();
    test_rst_mid_clear();
    test_clear_held();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
